// File: rtl/qspi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qspi_rx_pkg
// Description : Shared constants and types for the QSPI read-data aligner:
//               word-length encoding, receive FSM states and the default
//               pad-latency limit.
// Revision    : 1.0 - initial release
// ============================================================================
package qspi_rx_pkg;

    // Bytes-per-word encoding on the len input. Code 3 is also treated as 4 bytes.
    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_4B = 2'd2;

    // Default largest round-trip latency. The latency register is 3 bits wide,
    // so values above 7 are not meaningful.
    localparam int MAX_LATENCY_DEFAULT = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Index of the nibble that completes a word of the given length.
    function automatic logic [2:0] last_nibble(input logic [1:0] len_code);
        case (len_code)
            LEN_1B:  last_nibble = 3'd1;
            LEN_2B:  last_nibble = 3'd3;
            default: last_nibble = 3'd7;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : qspi_rx_fifo
// Description : Small synchronous FIFO. The head entry is taken straight from
//               the storage registers and reads as zero while empty. A push
//               into a full FIFO is accepted only when a pop frees a slot in
//               the same cycle; otherwise it is ignored. A pop while empty
//               is ignored.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write request and word
//               pop             - remove head entry
//               head            - current head word (0 when empty)
//               full, empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_rx_fifo
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop;
    logic             w_push;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign head   = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qspi_rx_aligner.sv
`default_nettype none
// ============================================================================
// Module      : qspi_rx_aligner
// Description : QSPI read-data capture stage. Delays the controller's sample
//               strobe by a latency latched from the data pins during reset,
//               captures nibbles on the delayed strobe, packs them into
//               1/2/4-byte little-endian words and queues them in a FIFO.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               latency_pins    - latency code, sampled while rst=1
//               qspi_data_in    - raw nibble {d3,d2,d1,d0}
//               start, stop     - begin / end a read stream (stop wins)
//               len             - bytes per word, sampled at start
//               sample_strobe   - zero-latency nibble-valid marker
//               data_out        - FIFO head word
//               data_valid      - FIFO non-empty
//               data_ready      - consumer accepts data_out
//               overflow        - sticky word-dropped flag
//               busy            - receiving or strobes in flight
//               ovf_count       - saturating drop counter
// Options     : QSPI_RX_OVF_COUNT_EN - enables the ovf_count counter;
//               when undefined, ovf_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_rx_aligner
    import qspi_rx_pkg::*;
#(
    parameter int MAX_LATENCY = MAX_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH  = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  latency_pins,
    input  logic [3:0]  qspi_data_in,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  len,
    input  logic        sample_strobe,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        overflow,
    output logic        busy,
    output logic [7:0]  ovf_count
);

    localparam logic [2:0] C_MAX_LAT = 3'(MAX_LATENCY);

    rx_state_t               r_state;
    logic [2:0]              r_lat;
    logic [1:0]              r_len;
    logic [2:0]              r_nib_cnt;
    logic [31:0]             r_word;
    logic [MAX_LATENCY-1:0]  r_pipe;

    logic [MAX_LATENCY:0]    w_taps;
    logic [MAX_LATENCY-1:0]  w_pipe_shift;
    logic                    w_eff_strobe;
    logic                    w_capture;
    logic [4:0]              w_shift;
    logic [31:0]             w_word_next;
    logic                    w_word_done;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_pop;
    logic                    w_drop;
    logic [2:0]              w_lat_clamped;

    assign w_lat_clamped = (latency_pins > C_MAX_LAT) ? C_MAX_LAT : latency_pins;

    // Tap 0 is the live strobe, tap k the strobe asserted k cycles ago.
    assign w_taps       = {r_pipe, sample_strobe};
    assign w_pipe_shift = MAX_LATENCY'({r_pipe, sample_strobe});
    assign w_eff_strobe = w_taps[r_lat];

    // start/stop flush in-flight state, so a coincident strobe is discarded.
    assign w_capture = (r_state == RECV) && w_eff_strobe && !start && !stop;

    // Bit position of the incoming nibble: byte index * 8, plus 4 for the
    // even (high) nibble of each byte.
    assign w_shift     = {r_nib_cnt[2:1], ~r_nib_cnt[0], 2'b00};
    assign w_word_next = r_word | ({28'd0, qspi_data_in} << w_shift);
    assign w_word_done = w_capture && (r_nib_cnt == last_nibble(r_len));

    assign w_pop      = data_valid && data_ready;
    assign w_drop     = w_word_done && w_fifo_full && !w_pop;
    assign data_valid = !w_fifo_empty;
    assign busy       = (r_state == RECV) || (|r_pipe);

    qspi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_word_done),
        .push_data (w_word_next),
        .pop       (w_pop),
        .head      (data_out),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lat     <= w_lat_clamped;
            r_len     <= LEN_1B;
            r_nib_cnt <= '0;
            r_word    <= '0;
            r_pipe    <= '0;
            overflow  <= 1'b0;
        end else if (stop) begin
            r_state   <= IDLE;
            r_nib_cnt <= '0;
            r_word    <= '0;
            r_pipe    <= '0;
        end else if (start) begin
            r_state   <= RECV;
            r_len     <= len;
            r_nib_cnt <= '0;
            r_word    <= '0;
            r_pipe    <= '0;
            overflow  <= 1'b0;
        end else begin
            r_pipe <= w_pipe_shift;
            if (w_capture) begin
                if (w_word_done) begin
                    r_nib_cnt <= '0;
                    r_word    <= '0;
                end else begin
                    r_nib_cnt <= r_nib_cnt + 3'd1;
                    r_word    <= w_word_next;
                end
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef QSPI_RX_OVF_COUNT_EN
    logic [7:0] r_ovf_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`else
    assign ovf_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qspi_rx_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tb_qspi_rx_aligner
// Description : Self-checking bench for qspi_rx_aligner: directed scenarios
//               followed by randomized traffic, compared every cycle with a
//               behavioural model built from strobe history and word queues.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_qspi_rx_aligner;

    localparam int MAXL  = 5;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  latency_pins;
    logic [3:0]  qspi_data_in;
    logic        start;
    logic        stop;
    logic [1:0]  len;
    logic        sample_strobe;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        overflow;
    logic        busy;
    logic [7:0]  ovf_count;

    always #5 clk = ~clk;

    qspi_rx_aligner #(
        .MAX_LATENCY (MAXL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .latency_pins  (latency_pins),
        .qspi_data_in  (qspi_data_in),
        .start         (start),
        .stop          (stop),
        .len           (len),
        .sample_strobe (sample_strobe),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .overflow      (overflow),
        .busy          (busy),
        .ovf_count     (ovf_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_lat;
    bit          m_recv;
    int          m_nbytes;
    int          m_nibs[$];
    logic [31:0] m_fifo[$];
    bit          m_ovf;
    int          m_ovf_cnt;
    int          m_strobes[$];   // cycles of strobes still inside the pipeline
    int          cyc = 0;

    task automatic model_edge();
        bit          pop;
        bit          eff;
        bit          cap;
        logic [31:0] word;
        if (rst) begin
            m_lat     = (int'(latency_pins) > MAXL) ? MAXL : int'(latency_pins);
            m_recv    = 0;
            m_nbytes  = 1;
            m_ovf     = 0;
            m_ovf_cnt = 0;
            m_nibs.delete();
            m_fifo.delete();
            m_strobes.delete();
        end else begin
            pop = (m_fifo.size() > 0) && data_ready;
            eff = 0;
            if (m_lat == 0) eff = sample_strobe;
            else foreach (m_strobes[i]) if (m_strobes[i] == cyc - m_lat) eff = 1;
            cap = m_recv && eff && !start && !stop;
            if (pop) void'(m_fifo.pop_front());
            if (cap) begin
                m_nibs.push_back(int'(qspi_data_in));
                if (m_nibs.size() == 2 * m_nbytes) begin
                    word = 0;
                    for (int k = 0; k < m_nbytes; k++)
                        word += 32'((m_nibs[2*k] * 16 + m_nibs[2*k+1]) << (8 * k));
                    m_nibs.delete();
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(word);
                    else begin
                        m_ovf = 1;
                        if (m_ovf_cnt < 255) m_ovf_cnt++;
                    end
                end
            end
            if (stop) begin
                m_recv = 0;
                m_nibs.delete();
                m_strobes.delete();
            end else if (start) begin
                m_recv   = 1;
                m_nbytes = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
                m_ovf    = 0;
                m_nibs.delete();
                m_strobes.delete();
            end else if (sample_strobe) begin
                m_strobes.push_back(cyc);
            end
            while (m_strobes.size() > 0 && m_strobes[0] < cyc - (MAXL - 1))
                void'(m_strobes.pop_front());
        end
        cyc++;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef QSPI_RX_OVF_COUNT_EN
        return 32'(m_ovf_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Apply current inputs for one clock edge and compare all outputs.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("data_valid", 32'(data_valid), 32'(m_fifo.size() > 0));
        check("data_out", data_out, (m_fifo.size() > 0) ? m_fifo[0] : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy", 32'(busy), 32'(m_recv || (m_strobes.size() > 0)));
        check("ovf_count", 32'(ovf_count), exp_cnt());
    endtask

    task automatic quiet();
        start = 0; stop = 0; sample_strobe = 0;
    endtask

    task automatic do_reset(input logic [2:0] pins);
        quiet();
        rst = 1; latency_pins = pins; data_ready = 0;
        step();
        step();
        rst = 0;
        latency_pins = 3'($urandom_range(0, 7));
    endtask

    task automatic begin_stream(input logic [1:0] l);
        quiet(); start = 1; len = l;
        step();
        start = 0;
    endtask

    logic [3:0] nb [8];

    initial begin
        rst = 1; latency_pins = 0; qspi_data_in = 0; len = 0; data_ready = 0;
        quiet();

        // 1: latency 3, 4-byte word
        do_reset(3'd3);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        begin_stream(2'd2);
        for (int k = 0; k <= 10; k++) begin
            sample_strobe = (k < 8);
            qspi_data_in  = (k >= 3) ? 4'(k - 2) : 4'hF;
            step();
            if (k == 9) check("t1_not_early", 32'(data_valid), 32'd0);
        end
        check("t1_valid", 32'(data_valid), 32'd1);
        check("t1_word", data_out, 32'h78563412);
        quiet(); data_ready = 1; step(); data_ready = 0;
        stop = 1; step(); stop = 0;

        // 2a: latency pins 7 clamp to 5
        do_reset(3'd7);
        begin_stream(2'd0);
        for (int k = 0; k <= 7; k++) begin
            sample_strobe = (k < 2);
            qspi_data_in  = 4'(k);
            step();
            if (k == 6) check("t2_clamp_word", data_out, 32'h00000056);
        end
        quiet(); data_ready = 1; step(); data_ready = 0;
        // 2b: zero latency
        do_reset(3'd0);
        begin_stream(2'd0);
        sample_strobe = 1; qspi_data_in = 4'hA; step();
        check("t2_zero_pending", 32'(data_valid), 32'd0);
        qspi_data_in = 4'h5; step();
        check("t2_zero_word", data_out, 32'h000000A5);
        quiet(); data_ready = 1; step(); data_ready = 0;

        // 3: overflow with a stalled consumer
        do_reset(3'd0);
        begin_stream(2'd0);
        for (int i = 0; i < 8; i++) nb[i] = 4'($urandom);
        for (int i = 0; i < 6; i++) begin
            sample_strobe = 1; qspi_data_in = nb[i]; step();
        end
        quiet();
        check("t3_overflow", 32'(overflow), 32'd1);
`ifdef QSPI_RX_OVF_COUNT_EN
        check("t3_cnt1", 32'(ovf_count), 32'd1);
`endif
        sample_strobe = 1; qspi_data_in = 4'($urandom); step(); step();
        quiet();
`ifdef QSPI_RX_OVF_COUNT_EN
        check("t3_cnt2", 32'(ovf_count), 32'd2);
`endif
        begin_stream(2'd0);
        check("t3_ovf_cleared", 32'(overflow), 32'd0);
        check("t3_head", data_out, {24'd0, nb[0], nb[1]});

        // 4: push and pop together while full
        sample_strobe = 1; qspi_data_in = nb[6]; step();
        qspi_data_in = nb[7]; data_ready = 1; step();
        quiet(); data_ready = 0;
        check("t4_no_drop", 32'(overflow), 32'd0);
        check("t4_head", data_out, {24'd0, nb[2], nb[3]});
        data_ready = 1; step();
        check("t4_next", data_out, {24'd0, nb[6], nb[7]});
        step(); data_ready = 0;
        check("t4_drained", 32'(data_valid), 32'd0);

        // 5: abort with strobes in flight
        do_reset(3'd2);
        begin_stream(2'd2);
        for (int i = 0; i < 6; i++) begin
            sample_strobe = 1; qspi_data_in = 4'($urandom); step();
        end
        quiet(); stop = 1; step(); stop = 0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_nopush", 32'(data_valid), 32'd0);
        begin_stream(2'd1);
        for (int k = 0; k < 6; k++) begin
            sample_strobe = (k < 4); qspi_data_in = 4'(k + 1); step();
        end
        check("t5_word", data_out, 32'h00005634);
        quiet(); data_ready = 1; step(); data_ready = 0;

        // 6: reset mid-stream, new latency from pins
        do_reset(3'd0);
        begin_stream(2'd2);
        for (int i = 0; i < 5; i++) begin
            sample_strobe = 1; qspi_data_in = 4'($urandom); step();
        end
        quiet(); rst = 1; latency_pins = 3'd4; sample_strobe = 1; step();
        check("t6_valid", 32'(data_valid), 32'd0);
        check("t6_data", data_out, 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        rst = 0; latency_pins = 3'd1;
        begin_stream(2'd0);
        for (int k = 0; k < 7; k++) begin
            sample_strobe = (k < 2); qspi_data_in = 4'(k); step();
            if (k == 5) check("t6_word", data_out, 32'h00000045);
        end

        // Randomized traffic
        do_reset(3'($urandom_range(0, 7)));
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 299) == 0);
            latency_pins  = 3'($urandom_range(0, 7));
            start         = ($urandom_range(0, 99) < 4);
            stop          = ($urandom_range(0, 99) < 2);
            len           = 2'($urandom);
            sample_strobe = ($urandom_range(0, 99) < 60);
            qspi_data_in  = 4'($urandom);
            data_ready    = ($urandom_range(0, 99) < 40);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qspi_rx_aligner.md
Name: qspi_rx_aligner

Overview:
- Read-data capture stage between QSPI data pins and the tinyQV memory controller.
- Compensates a board/pad round-trip latency of 0..MAX_LATENCY clk cycles, latched from the data pins during reset.
- Packs received nibbles into 1/2/4-byte little-endian words and hands them to the controller through a small valid/ready FIFO.

Parameters:
- MAX_LATENCY, 5: largest supported latency in clk cycles; also the strobe pipeline length.
- FIFO_DEPTH, 2: output word FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- latency_pins  in  3  latency code, sampled only while rst=1
- qspi_data_in  in  4  raw nibble from pins {d3,d2,d1,d0}
- start  in  1  begin a read stream; flushes in-flight state
- stop  in  1  end stream; flushes in-flight state
- len  in  2  bytes per word: 0=1, 1=2, 2=4, 3=4; sampled at start
- sample_strobe  in  1  controller marks cycle a zero-latency nibble is valid
- data_out  out  32  packed word; unused upper bytes zero
- data_valid  out  1  FIFO non-empty
- data_ready  in  1  consumer accepts data_out
- overflow  out  1  sticky; a completed word was dropped
- busy  out  1  state is RECV or a strobe is in flight
- ovf_count  out  8  saturating drop count (optional feature)

Behaviour:
Reset (rst=1 on a clk edge):
- lat_reg <= min(latency_pins, MAX_LATENCY) every cycle while rst=1; holds after release.
- Outputs: data_out=0, data_valid=0, overflow=0, busy=0, ovf_count=0.
- FIFO, strobe pipeline, packer and FSM cleared; state=IDLE.
- rst mid-stream discards everything; no partial word is output.

Strobe pipeline:
- MAX_LATENCY-bit shift register; bit0 <= sample_strobe.
- Effective strobe: lat_reg=0 uses sample_strobe directly; otherwise pipe[lat_reg-1]. A strobe is therefore honoured exactly lat_reg cycles after it is asserted.
- On the effective-strobe cycle, qspi_data_in is captured. Only captured while state=RECV.

FSM (IDLE, RECV):
- IDLE -> RECV on start: latches len; clears nibble/byte counters, partial word and overflow.
- RECV -> IDLE on stop: clears the strobe pipeline and partial word.
- start while in RECV restarts the stream: same clearing as IDLE->RECV, including the pipeline.
- If start and stop are asserted in the same cycle, stop wins.

Packing:
- Even nibble -> byte[7:4], odd nibble -> byte[3:0].
- Byte k goes to data_out[8k+7:8k].
- After 2*nbytes nibbles the word is pushed and the counters reset. The stream continues until stop.

FIFO:
- Registered, FIFO_DEPTH entries; data_out always shows the head.
- Pop when data_valid && data_ready.
- Push and pop in the same cycle are both allowed when full: the pop frees the slot.
- Push while full and no pop: the word is dropped and overflow is set. overflow clears only on start or rst.
- data_ready while empty has no effect.
- start and stop do NOT flush the FIFO; already completed words stay deliverable.

busy = (state==RECV) OR (pipeline non-zero).

Optional Feature:
Macro: QSPI_RX_OVF_COUNT_EN.
- Defined: ovf_count increments on each dropped word, saturates at 255, clears only on rst.
- Undefined: counter logic is omitted and ovf_count is tied to 0.

Decomposition:
Shared package qspi_rx_pkg holds:
- the len encoding constants (LEN_1B, LEN_2B, LEN_4B);
- the rx_state enum (IDLE, RECV);
- the MAX_LATENCY default.

One sub-module, qspi_rx_fifo: parameterised sync FIFO with push, pop, full, empty and a registered head. Packer, pipeline and FSM stay in the top module.

Test Plan:
1. Latch and capture: rst with latency_pins=3, then start len=2. Strobe 8 cycles with nibbles 1,2,3,4,5,6,7,8, pins delayed 3 cycles -> data_out=0x78563412, valid 3 cycles after the last strobe.
2. Clamp and zero latency: latency_pins=7 -> lat_reg=5 and capture at +5. latency_pins=0, len=0, nibbles A,5 -> data_out=0x000000A5 on the next cycle.
3. Overflow: data_ready=0, len=0, stream 3 bytes -> FIFO holds 2 words, overflow=1, ovf_count=1 when the macro is defined. A fourth byte -> ovf_count=2. After start, overflow=0.
4. Simultaneous push/pop when full: FIFO full, data_ready=1 in the cycle a word completes -> no drop, FIFO stays full, order preserved.
5. Abort: stop after 3 of 4 bytes with strobes still in flight -> no word pushed; busy=0 next cycle. Next start len=1 captures cleanly.
6. rst mid-stream: assert rst after 5 nibbles -> all outputs 0 next cycle. The new latency is taken from the pins.
